// File: rtl/melody_pkg.sv
// Shared types, note table and the half-period helper for melody_sequencer.
// Optional looping playback is enabled in the top by defining MELODY_SEQUENCER_LOOP_EN.
package melody_pkg;

  localparam int unsigned FREQ_W    = 16;
  localparam int unsigned DUR_W     = 12;
  localparam int unsigned HP_W      = 26;
  localparam int unsigned SEG_W     = 16;
  localparam int unsigned TABLE_LEN = 8;

  typedef struct packed {
    logic [FREQ_W-1:0] freq_hz;
    logic [DUR_W-1:0]  dur_ticks;
  } note_t;

  // freq_hz of 0 is a rest
  localparam note_t NOTE_TABLE [TABLE_LEN] = '{
    '{16'd262, 12'd400},
    '{16'd294, 12'd400},
    '{16'd330, 12'd400},
    '{16'd0,   12'd200},
    '{16'd349, 12'd400},
    '{16'd392, 12'd400},
    '{16'd440, 12'd400},
    '{16'd494, 12'd800}
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAY,
    ST_GAP,
    ST_DONE
  } state_e;

  // Clock cycles per half tone period; only ever evaluated on constants
  function automatic int unsigned half_period(int unsigned clk_hz, int unsigned freq_hz);
    if (freq_hz == 0) return 0;
    return clk_hz / (2 * freq_hz);
  endfunction

endpackage

// File: rtl/melody_sequencer_if.sv
// Control/status bundle between the player controller and melody_sequencer.
interface melody_sequencer_if #(
  parameter int unsigned IDX_W = 3
);
  logic             start;
  logic             stop;
  logic             audio_out;
  logic             playing;
  logic [IDX_W-1:0] note_idx;
  logic             done;

  modport master (
    output start, stop,
    input  audio_out, playing, note_idx, done
  );

  modport slave (
    input  start, stop,
    output audio_out, playing, note_idx, done
  );
endinterface

// File: rtl/tone_divider.sv
// Square-wave generator: toggles every half_period_i cycles, held low when cleared or at zero.
module tone_divider
  import melody_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            clr_i,
  input  logic [HP_W-1:0] half_period_i,
  output logic            sq_o
);

  logic [HP_W-1:0] cnt_q, cnt_d;
  logic            sq_q, sq_d;

  always_comb begin
    cnt_d = cnt_q;
    sq_d  = sq_q;
    if (clr_i || half_period_i == '0) begin
      cnt_d = '0;
      sq_d  = 1'b0;
    end else if (cnt_q == half_period_i - HP_W'(1)) begin
      cnt_d = '0;
      sq_d  = ~sq_q;
    end else begin
      cnt_d = cnt_q + HP_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      sq_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sq_q  <= sq_d;
    end
  end

  assign sq_o = sq_q;

endmodule

// File: rtl/melody_sequencer.sv
// Plays NOTE_TABLE as a square-wave tone stream with silent gaps between notes.
// Define MELODY_SEQUENCER_LOOP_EN to wrap back to note 0 instead of finishing.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned TICK_HZ   = 1000,
  parameter int unsigned NUM_NOTES = 8,
  parameter int unsigned GAP_TICKS = 20,
  parameter int unsigned IDX_W     = 3
) (
  input logic               clock,
  input logic               reset,
  melody_sequencer_if.slave bus
);

  localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [SEG_W-1:0]  GAP_LAST  = SEG_W'(GAP_TICKS - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_NOTES - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  note_idx_q, note_idx_d;
  logic [SEG_W-1:0]  seg_cnt_q, seg_cnt_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              playing_q, playing_d;
  logic              done_q, done_d;

  logic              tick_c;
  logic              seg_clr_c;
  logic              advance_c;
  logic              tone_clr_c;
  logic [SEG_W-1:0]  dur_last_c;
  logic [DUR_W-1:0]  dur_cur_c;
  logic [HP_W-1:0]   hp_cur_c;
  logic [HP_W-1:0]   hp_tab [NUM_NOTES];

  // Half periods are elaboration-time constants, one per table entry
  for (genvar g = 0; g < NUM_NOTES; g++) begin : g_hp
    assign hp_tab[g] = HP_W'(half_period(CLK_HZ, 32'(NOTE_TABLE[g].freq_hz)));
  end

  assign hp_cur_c   = hp_tab[note_idx_q];
  assign dur_cur_c  = NOTE_TABLE[note_idx_q].dur_ticks;
  assign dur_last_c = (dur_cur_c == '0) ? '0 : SEG_W'(dur_cur_c) - SEG_W'(1);
  assign tick_c     = (tick_cnt_q == TICK_LAST);

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    note_idx_d = note_idx_q;
    seg_cnt_d  = seg_cnt_q;
    tick_cnt_d = tick_c ? '0 : tick_cnt_q + TICK_W'(1);
    seg_clr_c  = 1'b0;
    advance_c  = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.stop) begin
          state_d    = ST_PLAY;
          note_idx_d = '0;
          seg_clr_c  = 1'b1;
        end
      end
      ST_PLAY: begin
        if (tick_c) begin
          if (seg_cnt_q == dur_last_c) begin
            seg_clr_c = 1'b1;
            if (GAP_TICKS > 0) state_d = ST_GAP;
            else               advance_c = 1'b1;
          end else begin
            seg_cnt_d = seg_cnt_q + SEG_W'(1);
          end
        end
      end
      ST_GAP: begin
        if (tick_c) begin
          if (seg_cnt_q == GAP_LAST) begin
            seg_clr_c = 1'b1;
            advance_c = 1'b1;
          end else begin
            seg_cnt_d = seg_cnt_q + SEG_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (advance_c) begin
      if (note_idx_q < LAST_IDX) begin
        note_idx_d = note_idx_q + IDX_W'(1);
        state_d    = ST_PLAY;
      end else begin
`ifdef MELODY_SEQUENCER_LOOP_EN
        note_idx_d = '0;
        state_d    = ST_PLAY;
        done_d     = 1'b1;
`else
        note_idx_d = '0;
        state_d    = ST_DONE;
`endif
      end
    end

    // Stop overrides everything, including a same-cycle wrap pulse
    if (state_q != ST_IDLE && bus.stop) begin
      state_d    = ST_IDLE;
      note_idx_d = '0;
      done_d     = 1'b0;
    end

    if (state_d == ST_DONE) done_d = 1'b1;

    if (seg_clr_c || state_d == ST_IDLE || state_d == ST_DONE) begin
      tick_cnt_d = '0;
      seg_cnt_d  = '0;
    end

    playing_d  = (state_d == ST_PLAY) || (state_d == ST_GAP);
    tone_clr_c = seg_clr_c || (state_d != ST_PLAY);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      note_idx_q <= '0;
      seg_cnt_q  <= '0;
      tick_cnt_q <= '0;
      playing_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      note_idx_q <= note_idx_d;
      seg_cnt_q  <= seg_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      playing_q  <= playing_d;
      done_q     <= done_d;
    end
  end

  tone_divider u_tone (
    .clock         (clock),
    .reset         (reset),
    .clr_i         (tone_clr_c),
    .half_period_i (hp_cur_c),
    .sq_o          (bus.audio_out)
  );

  assign bus.playing  = playing_q;
  assign bus.note_idx = note_idx_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: segment-timeline model compared every cycle plus directed timing checks.
module tb_melody_sequencer;

  localparam int unsigned CLK_HZ    = 20_000;
  localparam int unsigned TICK_HZ   = 4_000;
  localparam int unsigned NUM_NOTES = 8;
  localparam int unsigned GAP_TICKS = 2;
  localparam int unsigned IDX_W     = 3;
  localparam int TDIV = int'(CLK_HZ / TICK_HZ);
  localparam int FREQ [8] = '{262, 294, 330, 0, 349, 392, 440, 494};
  localparam int DUR  [8] = '{400, 400, 400, 200, 400, 400, 400, 800};

  logic clock = 1'b0;
  logic reset = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_done   = 0;

  // Model: 0 idle, 1 play, 2 gap, 3 done; m_t = cycles elapsed in current segment
  int m_st  = 0;
  int m_idx = 0;
  int m_t   = 0;
  bit m_wrap = 1'b0;

  melody_sequencer_if #(.IDX_W(IDX_W)) bus();

  melody_sequencer #(
    .CLK_HZ    (CLK_HZ),
    .TICK_HZ   (TICK_HZ),
    .NUM_NOTES (NUM_NOTES),
    .GAP_TICKS (GAP_TICKS),
    .IDX_W     (IDX_W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int seg_len(input int st, input int idx);
    if (st == 1) return ((DUR[idx] == 0) ? 1 : DUR[idx]) * TDIV;
    return int'(GAP_TICKS) * TDIV;
  endfunction

  task automatic m_advance();
    m_t = 0;
    if (m_idx < int'(NUM_NOTES) - 1) begin
      m_idx++;
      m_st = 1;
    end else begin
`ifdef MELODY_SEQUENCER_LOOP_EN
      m_idx  = 0;
      m_st   = 1;
      m_wrap = 1'b1;
`else
      m_idx = 0;
      m_st  = 3;
`endif
    end
  endtask

  function automatic logic exp_audio();
    int hp;
    if (m_st != 1 || FREQ[m_idx] == 0) return 1'b0;
    hp = int'(CLK_HZ) / (2 * FREQ[m_idx]);
    return ((m_t / hp) % 2) == 1;
  endfunction

  function automatic int sig_val(input int which);
    case (which)
      0:       return int'(bus.audio_out);
      1:       return int'(bus.note_idx);
      2:       return int'(bus.playing);
      default: return int'(bus.done);
    endcase
  endfunction

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Model update on the same edges the design sees
  initial forever begin
    @(posedge clock or posedge reset);
    m_wrap = 1'b0;
    if (reset) begin
      m_st = 0; m_idx = 0; m_t = 0;
    end else if (m_st != 0 && bus.stop) begin
      m_st = 0; m_idx = 0; m_t = 0;
    end else begin
      case (m_st)
        0: if (bus.start && !bus.stop) begin m_st = 1; m_idx = 0; m_t = 0; end
        1: begin
          if (m_t + 1 == seg_len(1, m_idx)) begin
            if (GAP_TICKS > 0) begin m_st = 2; m_t = 0; end
            else m_advance();
          end else m_t++;
        end
        2: if (m_t + 1 == seg_len(2, m_idx)) m_advance(); else m_t++;
        default: m_st = 0;
      endcase
    end
  end

  // Per-cycle comparison against the model
  initial forever begin
    @(negedge clock);
    check("audio_out", 32'(bus.audio_out), 32'(exp_audio()));
    check("playing",   32'(bus.playing),   32'(m_st == 1 || m_st == 2));
    check("note_idx",  32'(bus.note_idx),  (m_st == 1 || m_st == 2) ? m_idx : 0);
    check("done",      32'(bus.done),      32'(m_st == 3 || m_wrap));
    if (bus.done === 1'b1) n_done++;
  end

  task automatic wait_for(input string name, input int which, input int val,
                          input int budget, output int at);
    int n;
    n  = 0;
    at = -1;
    while (at < 0 && n < budget) begin
      @(negedge clock);
      if (sig_val(which) == val) at = cyc;
      n++;
    end
    if (at < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: timeout after %0d cycles, value %0d never reached", name, budget, val);
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  initial begin
    int t0, t1, at, rest_hi, r7, f7, prev_a, done_at, play_at_done, idx_at_done;
    bus.start = 1'b0;
    bus.stop  = 1'b0;

    repeat (20) @(negedge clock);
    check("reset_audio",   32'(bus.audio_out), 0);
    check("reset_playing", 32'(bus.playing),   0);
    check("reset_idx",     32'(bus.note_idx),  0);
    check("reset_done",    32'(bus.done),      0);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    check("idle_playing", 32'(bus.playing), 0);

    bus.start = 1'b1;
    bus.stop  = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check("start_stop_idle", 32'(bus.playing), 0);
    repeat (3) @(negedge clock);

    pulse_start();
    t0 = cyc;
    check("start_playing", 32'(bus.playing),   1);
    check("start_idx",     32'(bus.note_idx),  0);
    check("start_audio",   32'(bus.audio_out), 0);
    wait_for("note0_rise", 0, 1, 200, at);
    check("note0_first_toggle", 32'(at - t0), 38);
    t1 = at;
    wait_for("note0_fall", 0, 0, 200, at);
    check("note0_half_period", 32'(at - t1), 38);
    wait_for("note1", 1, 1, 3000, at);
    check("note0_plus_gap", 32'(at - t0), 2010);

    wait_for("note2", 1, 2, 5000, at);
    repeat (7) @(negedge clock);
    pulse_start();
    repeat (2) @(negedge clock);
    check("start_ignored_idx", 32'(bus.note_idx), 2);

    wait_for("note5", 1, 5, 8000, at);
    repeat (30) @(negedge clock);
    bus.stop = 1'b1;
    @(negedge clock);
    bus.stop = 1'b0;
    check("stop_playing", 32'(bus.playing),   0);
    check("stop_idx",     32'(bus.note_idx),  0);
    check("stop_audio",   32'(bus.audio_out), 0);
    check("stop_no_done", 32'(n_done),        0);
    repeat (5) @(negedge clock);

    pulse_start();
    check("restart_playing", 32'(bus.playing),  1);
    check("restart_idx",     32'(bus.note_idx), 0);
    wait_for("note6", 1, 6, 15000, at);
    repeat (40) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("async_reset_audio",   32'(bus.audio_out), 0);
    check("async_reset_playing", 32'(bus.playing),   0);
    check("async_reset_idx",     32'(bus.note_idx),  0);
    check("async_reset_done",    32'(bus.done),      0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);

    pulse_start();
    t0 = cyc;
    rest_hi = 0; r7 = -1; f7 = -1; prev_a = 0; done_at = -1;
    play_at_done = -1; idx_at_done = -1;
    for (int i = 0; i < 20000 && done_at < 0; i++) begin
      @(negedge clock);
      if (bus.note_idx == 3'd3 && bus.playing && bus.audio_out) rest_hi++;
      if (bus.note_idx == 3'd7 && bus.audio_out && prev_a == 0 && r7 < 0) r7 = cyc;
      else if (bus.note_idx == 3'd7 && !bus.audio_out && prev_a == 1 && r7 >= 0 && f7 < 0) f7 = cyc;
      prev_a = int'(bus.audio_out);
      if (bus.done) begin
        done_at      = cyc;
        play_at_done = int'(bus.playing);
        idx_at_done  = int'(bus.note_idx);
      end
    end
    if (done_at < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL full_pass: timeout, done never pulsed");
    end
    check("pass_length",       32'(done_at - t0), 17080);
    check("rest_silent",       32'(rest_hi),      0);
    check("note7_half_period", 32'(f7 - r7),      20);
    check("done_idx",          32'(idx_at_done),  0);
`ifdef MELODY_SEQUENCER_LOOP_EN
    check("wrap_playing", 32'(play_at_done), 1);
    @(negedge clock);
    check("done_width", 32'(bus.done), 0);
    t1 = done_at;
    wait_for("second_wrap", 3, 1, 20000, at);
    check("loop_pass_length", 32'(at - t1), 17080);
    bus.stop = 1'b1;
    @(negedge clock);
    bus.stop = 1'b0;
    check("loop_stop_playing", 32'(bus.playing), 0);
    repeat (20) @(negedge clock);
    check("done_count", 32'(n_done), 2);
`else
    check("done_playing_low", 32'(play_at_done), 0);
    @(negedge clock);
    check("done_width", 32'(bus.done), 0);
    repeat (50) @(negedge clock);
    check("done_count", 32'(n_done), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
